// File: rtl/imem_arbiter_if.sv
// Instruction-memory port bundle: IF and LS request/response plus memory side.
interface imem_arbiter_if #(
  parameter int IMEM_W = 13
);
  logic              if_req_i;
  logic [IMEM_W-1:0] if_addr_i;
  logic              if_gnt_o;
  logic              if_rvalid_o;
  logic [31:0]       if_rdata_o;
  logic              flush_i;
  logic              ls_req_i;
  logic [IMEM_W-1:0] ls_addr_i;
  logic              ls_gnt_o;
  logic              ls_rvalid_o;
  logic [31:0]       ls_rdata_o;
  logic              ls_err_o;
  logic [IMEM_W-1:0] paddr_o;
  logic [31:0]       prdata_i;

  modport slave (
    input  if_req_i, if_addr_i, flush_i,
    input  ls_req_i, ls_addr_i, prdata_i,
    output if_gnt_o, if_rvalid_o, if_rdata_o,
    output ls_gnt_o, ls_rvalid_o, ls_rdata_o,
    output ls_err_o, paddr_o
  );

  modport master (
    output if_req_i, if_addr_i, flush_i,
    output ls_req_i, ls_addr_i, prdata_i,
    input  if_gnt_o, if_rvalid_o, if_rdata_o,
    input  ls_gnt_o, ls_rvalid_o, ls_rdata_o,
    input  ls_err_o, paddr_o
  );
endinterface

// File: rtl/imem_arbiter.sv
// Shares the imem read port between fetch and LS; fetch wins,
// a starvation counter forces an LS grant after STARVE_MAX denials.
module imem_arbiter #(
  parameter int IMEM_W     = 13,
  parameter int STARVE_MAX = 4
) (
  input logic           clk_i,
  input logic           rst_i,
  imem_arbiter_if.slave bus
);

  localparam logic [3:0] CNT_MAX = 4'(STARVE_MAX);

  logic        force_ls;
  logic        if_gnt;
  logic        ls_gnt;
  logic        if_take;
  logic [3:0]  starve_cnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        ls_rvalid;
  logic [31:0] ls_rdata;
  logic        ls_err;

  always_comb begin
    force_ls = (starve_cnt == CNT_MAX);
    ls_gnt   = bus.ls_req_i & (~bus.if_req_i | force_ls);
    if_gnt   = bus.if_req_i & ~ls_gnt;
    if_take  = if_gnt & ~bus.flush_i;
  end

  assign bus.if_gnt_o    = if_gnt;
  assign bus.ls_gnt_o    = ls_gnt;
  assign bus.paddr_o     = ls_gnt ? bus.ls_addr_i
                                  : bus.if_addr_i;
  assign bus.if_rvalid_o = if_rvalid;
  assign bus.if_rdata_o  = if_rdata;
  assign bus.ls_rvalid_o = ls_rvalid;
  assign bus.ls_rdata_o  = ls_rdata;
  assign bus.ls_err_o    = ls_err;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      starve_cnt <= '0;
    end else if (ls_gnt || !bus.ls_req_i) begin
      starve_cnt <= '0;
    end else if (starve_cnt != CNT_MAX) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      if_rvalid <= 1'b0;
      if_rdata  <= '0;
      ls_rvalid <= 1'b0;
      ls_rdata  <= '0;
      ls_err    <= 1'b0;
    end else begin
      if_rvalid <= if_take;
      ls_rvalid <= ls_gnt;
      ls_err    <= ls_gnt & (|bus.ls_addr_i[1:0]);
      if (if_take) if_rdata <= bus.prdata_i;
      // misaligned LS still gets the word the memory returns
      if (ls_gnt)  ls_rdata <= bus.prdata_i;
    end
  end

endmodule

// File: tb/tb_imem_arbiter.sv
// Scoreboard bench for imem_arbiter: directed cases then random traffic.
module tb_imem_arbiter;

  localparam int AW = 13;
  localparam int SM = 4;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;

  imem_arbiter_if #(.IMEM_W(AW)) bus ();

  imem_arbiter #(.IMEM_W(AW), .STARVE_MAX(SM)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus.slave)
  );

  always #5 clk_i = ~clk_i;

  logic [31:0] mem [2048];
  assign bus.prdata_i = mem[bus.paddr_o[12:2]];

  int errs   = 0;
  int checks = 0;

  logic [31:0] if_q [$];
  logic [32:0] ls_q [$];
  logic [31:0] last_if = '0;
  logic [31:0] last_ls = '0;
  int          m_cnt   = 0;
  int          m_wait  = 0;

  function automatic logic [31:0] word(input int i);
    if (i == 4)  return 32'hDEADBEEF;
    if (i < 16)  return 32'(i << 2);
    return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h @%0t",
               tag, got, exp, $time);
    end
  endtask

  // Called just after a rising edge; returns the model's grants.
  task automatic cycle(input logic ir, input logic [AW-1:0] ia,
                       input logic lr, input logic [AW-1:0] la,
                       input logic fl,
                       output logic ig, output logic lg);
    logic [31:0] e;
    logic [32:0] le;
    int nxt;
    bus.if_req_i  = ir;
    bus.if_addr_i = ia;
    bus.ls_req_i  = lr;
    bus.ls_addr_i = la;
    bus.flush_i   = fl;
    @(negedge clk_i);
    lg = lr & (~ir | (m_cnt == SM));
    ig = ir & ~lg;
    check("if_gnt", 64'(bus.if_gnt_o), 64'(ig));
    check("ls_gnt", 64'(bus.ls_gnt_o), 64'(lg));
    if (lg) check("paddr_ls", 64'(bus.paddr_o), 64'(la));
    if (ig) check("paddr_if", 64'(bus.paddr_o), 64'(ia));
    if (ig && !fl) if_q.push_back(word(int'(ia >> 2)));
    if (lg) ls_q.push_back({la[1:0] != 2'b00,
                            word(int'(la >> 2))});
    if (lg) check("ls_wait_ok", 64'(m_wait <= SM), 64'd1);
    if (lg || !lr) begin
      nxt = 0;
      m_wait = 0;
    end else begin
      nxt = (m_cnt == SM) ? SM : m_cnt + 1;
      m_wait++;
    end
    @(posedge clk_i);
    #1;
    m_cnt = nxt;
    check("if_rvalid", 64'(bus.if_rvalid_o),
          64'(if_q.size() != 0));
    if (if_q.size() != 0) begin
      e = if_q.pop_front();
      last_if = e;
      check("if_rdata", 64'(bus.if_rdata_o), 64'(e));
    end else begin
      check("if_hold", 64'(bus.if_rdata_o), 64'(last_if));
    end
    check("ls_rvalid", 64'(bus.ls_rvalid_o),
          64'(ls_q.size() != 0));
    if (ls_q.size() != 0) begin
      le = ls_q.pop_front();
      last_ls = le[31:0];
      check("ls_rdata", 64'(bus.ls_rdata_o), 64'(le[31:0]));
      check("ls_err", 64'(bus.ls_err_o), 64'(le[32]));
    end else begin
      check("ls_hold", 64'(bus.ls_rdata_o), 64'(last_ls));
      check("ls_err0", 64'(bus.ls_err_o), 64'd0);
    end
  endtask

  logic ig, lg;
  logic ip, lp;
  logic [AW-1:0] ia, la;
  int n;

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = word(i);
    bus.if_req_i  = 1'b0;
    bus.if_addr_i = '0;
    bus.ls_req_i  = 1'b0;
    bus.ls_addr_i = '0;
    bus.flush_i   = 1'b0;

    #2 rst_i = 1'b1;
    #1;
    check("rst_if_rvalid", 64'(bus.if_rvalid_o), 64'd0);
    check("rst_if_rdata", 64'(bus.if_rdata_o), 64'd0);
    check("rst_ls_rvalid", 64'(bus.ls_rvalid_o), 64'd0);
    check("rst_ls_rdata", 64'(bus.ls_rdata_o), 64'd0);
    check("rst_ls_err", 64'(bus.ls_err_o), 64'd0);
    @(posedge clk_i);
    #1 rst_i = 1'b0;

    // uncontended fetch
    for (int i = 0; i < 3; i++)
      cycle(1'b1, AW'(i * 4), 1'b0, '0, 1'b0, ig, lg);

    // partial starvation, then reset with a response in flight
    cycle(1'b1, 13'h00C, 1'b1, 13'h020, 1'b0, ig, lg);
    cycle(1'b1, 13'h010, 1'b1, 13'h020, 1'b0, ig, lg);
    check("pre_rst_valid", 64'(bus.if_rvalid_o), 64'd1);
    bus.if_req_i = 1'b0;
    bus.ls_req_i = 1'b0;
    #2 rst_i = 1'b1;
    #1;
    check("mid_if_rvalid", 64'(bus.if_rvalid_o), 64'd0);
    check("mid_if_rdata", 64'(bus.if_rdata_o), 64'd0);
    check("mid_ls_rvalid", 64'(bus.ls_rvalid_o), 64'd0);
    check("mid_ls_rdata", 64'(bus.ls_rdata_o), 64'd0);
    check("mid_ls_err", 64'(bus.ls_err_o), 64'd0);
    if_q.delete();
    ls_q.delete();
    last_if = '0;
    last_ls = '0;
    m_cnt  = 0;
    m_wait = 0;
    @(posedge clk_i);
    #1 rst_i = 1'b0;

    // contention: LS must win exactly in cycle SM
    for (int c = 0; c <= SM; c++) begin
      cycle(1'b1, AW'(c * 4), 1'b1, 13'h024, 1'b0, ig, lg);
      check("starve_lg", 64'(lg), 64'(c == SM));
    end
    cycle(1'b1, 13'h040, 1'b0, '0, 1'b0, ig, lg);

    // LS only, misaligned then aligned
    cycle(1'b0, '0, 1'b1, 13'h012, 1'b0, ig, lg);
    cycle(1'b0, '0, 1'b1, 13'h010, 1'b0, ig, lg);
    check("deadbeef", 64'(bus.ls_rdata_o), 64'hDEADBEEF);

    // flush kills fetch response, LS unaffected
    cycle(1'b1, 13'h030, 1'b0, '0, 1'b1, ig, lg);
    cycle(1'b0, '0, 1'b1, 13'h014, 1'b1, ig, lg);
    cycle(1'b0, '0, 1'b0, '0, 1'b0, ig, lg);

    // random traffic with request holding
    ip = 1'b0;
    lp = 1'b0;
    ia = '0;
    la = '0;
    for (int c = 0; c < 10000; c++) begin
      if (!ip && $urandom_range(0, 3) != 0) begin
        ip = 1'b1;
        ia = AW'($urandom_range(0, 8191));
      end
      if (!lp && $urandom_range(0, 3) == 0) begin
        lp = 1'b1;
        la = AW'($urandom_range(0, 8191));
      end
      n = $urandom_range(0, 7);
      cycle(ip, ia, lp, la, n == 0, ig, lg);
      if (ig) ip = 1'b0;
      if (lg) lp = 1'b0;
    end
    cycle(1'b0, '0, 1'b0, '0, 1'b0, ig, lg);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
